// File: rtl/fp_div_sched_pkg.sv
// fp_div_sched_pkg: shared types and constants for the divider scheduler
package fp_div_sched_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
   typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_DIVZ = 2'b01, ERR_TMO = 2'b10} err_e;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;
   localparam logic [7:0]  EXP_ZERO = 8'h00;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr with wrap
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt
);
   logic [N-1:0] rot, rg;
   // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
   assign rot = N'({req, req} >> ptr);
   assign rg  = rot & (~rot + 1'b1);
   assign gnt = N'({rg, rg} << ptr >> N);
endmodule

// File: rtl/fp_div_sched.sv
// fp_div_sched: shares one external fp divider among N_REQ requesters, one op in flight
module fp_div_sched
   import fp_div_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [32*N_REQ-1:0]        req_num1,
   input  logic [32*N_REQ-1:0]        req_num2,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic [31:0]                rsp_result,
   output logic [1:0]                 rsp_err,
   output logic                       div_start,
   output logic [31:0]                div_num1,
   output logic [31:0]                div_num2,
   input  logic                       div_valid,
   input  logic [31:0]                div_result
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT);
   state_e          state_q;
   err_e            err_q;
   logic [IW-1:0]   ptr_q, id_q, gid;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     num1_q, num2_q, res_q, n1, n2;
   logic [N_REQ-1:0] gnt;

   rr_arbiter #(.N(N_REQ)) u_arb (.req(req_valid), .ptr(ptr_q), .gnt(gnt));

   always_comb begin
      gid = '0;
      for (int i = 0; i < N_REQ; i++)
         if (gnt[i]) gid = IW'(i);
   end

   assign n1    = req_num1[32*gid +: 32];
   assign n2    = req_num2[32*gid +: 32];
   assign cnt_d = cnt_q + 1'b1;

   assign req_ready  = (state_q == IDLE && !rst) ? gnt : '0;
   assign rsp_valid  = state_q == RESP;
   assign rsp_id     = id_q;
   assign rsp_result = res_q;
   assign rsp_err    = err_q;
   assign div_start  = state_q == ISSUE;
   assign div_num1   = num1_q;
   assign div_num2   = num2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         id_q    <= '0;
         num1_q  <= '0;
         num2_q  <= '0;
         res_q   <= '0;
         err_q   <= ERR_OK;
      end else begin
         case (state_q)
            IDLE: if (|gnt) begin
               id_q   <= gid;
               num1_q <= n1;
               num2_q <= n2;
               // zero/subnormal divisor is answered locally as signed infinity
               if (n2[30:23] == EXP_ZERO) begin
                  res_q   <= {n1[31] ^ n2[31], 8'hFF, 23'h0};
                  err_q   <= ERR_DIVZ;
                  state_q <= RESP;
               end else state_q <= ISSUE;
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_d;
               if (div_valid) begin
                  res_q   <= div_result;
                  err_q   <= ERR_OK;
                  state_q <= RESP;
               end else if (cnt_d == CW'(TIMEOUT - 1)) begin
                  res_q   <= QNAN;
                  err_q   <= ERR_TMO;
                  state_q <= RESP;
               end
            end
            RESP: if (rsp_ready) begin
               ptr_q   <= (id_q == IW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_div_sched.sv
// tb_fp_div_sched: directed self-checking bench, bench plays the shared divider
module tb_fp_div_sched;
   localparam int N = 4;
   logic            clk = 1'b0, rst = 1'b1;
   logic [N-1:0]    req_valid = '0, req_ready;
   logic [32*N-1:0] req_num1 = '0, req_num2 = '0;
   logic            rsp_valid, rsp_ready = 1'b0;
   logic [1:0]      rsp_id, rsp_err;
   logic [31:0]     rsp_result, div_num1, div_num2, div_result = '0;
   logic            div_start, div_valid = 1'b0;
   int checks = 0, errors = 0, n_start = 0, s = 0, k = 0;
   int order [6] = '{0, 1, 2, 3, 0, 1};

   always #5 clk = ~clk;
   always @(negedge clk) if (div_start) n_start++;

   fp_div_sched #(.N_REQ(N), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_num1(req_num1), .req_num2(req_num2), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_err(rsp_err), .div_start(div_start), .div_num1(div_num1),
      .div_num2(div_num2), .div_valid(div_valid), .div_result(div_result)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
      req_num1[32*i +: 32] = a;
      req_num2[32*i +: 32] = b;
   endtask

   task automatic ack;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      req_valid = 4'hF;
      tick();
      tick();
      chk("rst_rdy", 32'(req_ready), 32'h0);
      chk("rst_rspv", 32'(rsp_valid), 32'h0);
      chk("rst_start", 32'(div_start), 32'h0);
      chk("rst_num1", div_num1, 32'h0);
      chk("rst_res", rsp_result, 32'h0);
      chk("rst_err", 32'(rsp_err), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_ops(i, 32'h3F80_0000, 32'h0);
      rsp_ready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         #1;
         chk("rr_gnt", 32'(req_ready), 32'(1) << order[j]);
         tick();
         chk("rr_id", 32'(rsp_id), 32'(order[j]));
         chk("rr_res", rsp_result, 32'h7F80_0000);
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      // requester 2 normal path, divider answers on the 10th WAIT cycle
      set_ops(2, 32'h3F80_0000, 32'h4000_0000);
      req_valid = 4'b0100;
      #1;
      chk("n_gnt", 32'(req_ready), 32'h4);
      s = n_start;
      tick();
      req_valid = '0;
      chk("n_start", 32'(div_start), 32'h1);
      chk("n_num1", div_num1, 32'h3F80_0000);
      chk("n_num2", div_num2, 32'h4000_0000);
      for (int j = 0; j < 10; j++) tick();
      chk("n_wait", 32'(rsp_valid), 32'h0);
      div_valid = 1'b1;
      div_result = 32'h3F00_0000;
      tick();
      div_valid = 1'b0;
      chk("n_rspv", 32'(rsp_valid), 32'h1);
      chk("n_id", 32'(rsp_id), 32'h2);
      chk("n_res", rsp_result, 32'h3F00_0000);
      chk("n_err", 32'(rsp_err), 32'h0);
      chk("n_nstart", 32'(n_start - s), 32'h1);
      ack();
      // zero divisor from all requesters, ptr now 3, then hold the response
      for (int i = 0; i < N; i++) set_ops(i, 32'hC040_0000, 32'h0);
      req_valid = 4'hF;
      #1;
      chk("z_gnt", 32'(req_ready), 32'h8);
      s = n_start;
      tick();
      chk("z_rspv", 32'(rsp_valid), 32'h1);
      chk("z_res", rsp_result, 32'hFF80_0000);
      chk("z_err", 32'(rsp_err), 32'h1);
      chk("z_id", 32'(rsp_id), 32'h3);
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("h_rspv", 32'(rsp_valid), 32'h1);
         chk("h_res", rsp_result, 32'hFF80_0000);
         chk("h_err", 32'(rsp_err), 32'h1);
         chk("h_id", 32'(rsp_id), 32'h3);
         chk("h_rdy", 32'(req_ready), 32'h0);
      end
      chk("z_nstart", 32'(n_start - s), 32'h0);
      ack();
      chk("wrap_gnt", 32'(req_ready), 32'h1);
      req_valid = '0;
      // subnormal divisor counts as zero
      set_ops(1, 32'h3F80_0000, 32'h0000_0001);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      chk("sub_res", rsp_result, 32'h7F80_0000);
      chk("sub_err", 32'(rsp_err), 32'h1);
      ack();
      // timeout, with a stray div_valid during ISSUE that must be ignored
      set_ops(0, 32'h3F80_0000, 32'h4000_0000);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      chk("to_start", 32'(div_start), 32'h1);
      div_valid = 1'b1;
      div_result = 32'h1234_5678;
      tick();
      div_valid = 1'b0;
      k = 1;
      while (!rsp_valid && k < 200) begin
         tick();
         k++;
      end
      chk("to_lat", 32'(k), 32'd64);
      chk("to_res", rsp_result, 32'h7FC0_0000);
      chk("to_err", 32'(rsp_err), 32'h2);
      div_valid = 1'b1;
      div_result = 32'hDEAD_BEEF;
      tick();
      div_valid = 1'b0;
      chk("resp_ign", rsp_result, 32'h7FC0_0000);
      ack();
      // reset during WAIT abandons the op and returns ptr to 0
      set_ops(1, 32'h4080_0000, 32'h4000_0000);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("wr_rspv", 32'(rsp_valid), 32'h0);
      chk("wr_start", 32'(div_start), 32'h0);
      chk("wr_rdy", 32'(req_ready), 32'h0);
      chk("wr_num1", div_num1, 32'h0);
      chk("wr_res", rsp_result, 32'h0);
      set_ops(0, 32'h4080_0000, 32'h4000_0000);
      req_valid = 4'b0011;
      #1;
      chk("wr_ptr", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("wr_start2", 32'(div_start), 32'h1);
      tick();
      tick();
      tick();
      div_valid = 1'b1;
      div_result = 32'h4000_0000;
      tick();
      div_valid = 1'b0;
      chk("wr_rspv2", 32'(rsp_valid), 32'h1);
      chk("wr_id", 32'(rsp_id), 32'h0);
      chk("wr_res2", rsp_result, 32'h4000_0000);
      chk("wr_err", 32'(rsp_err), 32'h0);
      ack();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
